// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: FSM state encodings and default RAM geometry
// shared by the arbiter, the RAM and the program loader.
package ram_arbiter_pkg;

  localparam int RAM_ADDR_WIDTH = 10;
  localparam int RAM_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_ACCESS = 2'd1,
    STATE_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: both requester ports plus the RAM-side bus.
// slave = arbiter view, master = requesters/RAM view.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = ram_arbiter_pkg::RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = ram_arbiter_pkg::RAM_DATA_WIDTH
);

  logic                  req0_valid;
  logic                  req0_write;
  logic [ADDR_WIDTH-1:0] req0_address;
  logic [DATA_WIDTH-1:0] req0_data_in;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_data_out;

  logic                  req1_valid;
  logic                  req1_write;
  logic [ADDR_WIDTH-1:0] req1_address;
  logic [DATA_WIDTH-1:0] req1_data_in;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_data_out;

  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  ram_write_enable;
  logic [DATA_WIDTH-1:0] ram_data_out;

  modport slave (
    input  req0_valid, req0_write, req0_address, req0_data_in,
    input  req1_valid, req1_write, req1_address, req1_data_in,
    input  ram_data_out,
    output req0_ready, req0_data_out,
    output req1_ready, req1_data_out,
    output ram_address, ram_data_in, ram_write_enable
  );

  modport master (
    output req0_valid, req0_write, req0_address, req0_data_in,
    output req1_valid, req1_write, req1_address, req1_data_in,
    output ram_data_out,
    input  req0_ready, req0_data_out,
    input  req1_ready, req1_data_out,
    input  ram_address, ram_data_in, ram_write_enable
  );

endinterface

// File: rtl/ram_arbiter_grant.sv
// ram_arbiter_grant: combinational winner pick from the two valids,
// an exclude mask and (RAM_ARB_ROUND_ROBIN_EN) the last-grant bit.
module ram_arbiter_grant (
  input  logic [1:0] valid_i,
  input  logic [1:0] excl_i,
`ifdef RAM_ARB_ROUND_ROBIN_EN
  input  logic       last_i,
`endif
  output logic       any_o,
  output logic       win_o
);

  logic [1:0] v;
  logic       tie;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // favour the port not granted most recently
  assign tie = ~last_i;
`else
  assign tie = 1'b0;
`endif

  assign v     = valid_i & ~excl_i;
  assign any_o = |v;

  always_comb begin
    win_o = 1'b0;
    unique case (1'b1)
      (v == 2'b11): win_o = tie;
      (v == 2'b10): win_o = 1'b1;
      default:      win_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises two requesters onto one 1024x16 RAM.
// Ports: clk, reset (sync, active-high), bus (ram_arbiter_if.slave).
// Macro: RAM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  state_t                state_q;
  logic                  grant_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            ready_q;
  logic [1:0]            rd_q;
  logic [DATA_WIDTH-1:0] dout0_q;
  logic [DATA_WIDTH-1:0] dout1_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic                  last_q;
`endif

  logic                  any;
  logic                  win;
  logic [1:0]            excl;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // the port just served still shows valid during DONE
  assign excl = (state_q != STATE_DONE) ? 2'b00 :
                (grant_q ? 2'b10 : 2'b01);

  ram_arbiter_grant u_grant (
    .valid_i ({bus.req1_valid, bus.req0_valid}),
    .excl_i  (excl),
`ifdef RAM_ARB_ROUND_ROBIN_EN
    .last_i  (last_q),
`endif
    .any_o   (any),
    .win_o   (win)
  );

  assign sel_wr   = win ? bus.req1_write   : bus.req0_write;
  assign sel_addr = win ? bus.req1_address : bus.req0_address;
  assign sel_data = win ? bus.req1_data_in : bus.req0_data_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STATE_IDLE;
      grant_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 2'b00;
      rd_q    <= 2'b00;
      dout0_q <= '0;
      dout1_q <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      ready_q <= 2'b00;
      rd_q    <= 2'b00;
      unique case (state_q)
        STATE_IDLE: begin
          if (any) begin
            grant_q <= win;
            wr_q    <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_data;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_q  <= win;
`endif
            state_q <= STATE_ACCESS;
          end
        end
        STATE_ACCESS: begin
          ready_q[grant_q] <= 1'b1;
          rd_q[grant_q]    <= ~wr_q;
          state_q          <= STATE_DONE;
        end
        STATE_DONE: begin
          if (rd_q[0]) dout0_q <= bus.ram_data_out;
          if (rd_q[1]) dout1_q <= bus.ram_data_out;
          if (any) begin
            grant_q <= win;
            wr_q    <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_data;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_q  <= win;
`endif
            state_q <= STATE_ACCESS;
          end else begin
            state_q <= STATE_IDLE;
          end
        end
        default: state_q <= STATE_IDLE;
      endcase
    end
  end

  assign bus.ram_address      = addr_q;
  assign bus.ram_data_in      = wdata_q;
  // reset kills an in-flight write in the same cycle
  assign bus.ram_write_enable =
    (state_q == STATE_ACCESS) & wr_q & ~reset;

  assign bus.req0_ready = ready_q[0];
  assign bus.req1_ready = ready_q[1];

  // RAM output is already registered; expose it alongside ready
  assign bus.req0_data_out = rd_q[0] ? bus.ram_data_out : dout0_q;
  assign bus.req1_data_out = rd_q[1] ? bus.ram_data_out : dout1_q;

endmodule
